// File: rtl/star_scheduler.sv
// ============================================================================
// Module   : star_scheduler
// Purpose  : Round-robin star collision scheduler sharing one overlap
//            comparator across a per-level star table, once per frame.
// Options  : `define STAR_RESPAWN_EN to build per-star respawn timers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module star_scheduler #(
    parameter int NUM_STARS      = 4,
    parameter int STAR_SIZE      = 12,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic                    sys_clk,
    input  logic                    RST,
    input  logic                    frame_tick,
    input  logic                    level_restart,
    input  logic [9:0]              char_X,
    input  logic [9:0]              char_Y,
    input  logic [10*NUM_STARS-1:0] star_xs,
    input  logic [10*NUM_STARS-1:0] star_ys,
    output logic [NUM_STARS-1:0]    star_en,
    output logic                    touch,
    output logic [2:0]              touch_idx,
    output logic [7:0]              star_count,
    output logic                    scan_done,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_last = 3'(NUM_STARS - 1);
    localparam logic [9:0] c_size = 10'(STAR_SIZE);

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_idx;
    logic [9:0]             r_cx;
    logic [9:0]             r_cy;
    logic [NUM_STARS-1:0]   r_star_en;
    logic                   r_touch;
    logic [2:0]             r_touch_idx;
    logic [7:0]             r_count;
    logic                   r_scan_done;

    logic                   w_scan_start;
    logic                   w_eval;
    logic [9:0]             w_sx;
    logic [9:0]             w_sy;
    logic                   w_cur_en;
    logic                   w_xhit;
    logic                   w_yhit;
    logic                   w_hit;
    logic [NUM_STARS-1:0]   w_hit_mask;
    logic [NUM_STARS-1:0]   w_respawn;
    logic [NUM_STARS-1:0]   w_testable;
    logic [9:0]             w_cx_s;
    logic [9:0]             w_cy_s;
    logic [9:0]             w_sx_s;
    logic [9:0]             w_sy_s;

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (frame_tick) w_next = ST_SCAN;
            ST_SCAN: if (r_idx == c_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (level_restart) begin
            w_next = ST_IDLE;
        end
    end

    assign w_scan_start = (r_state == ST_IDLE) && frame_tick && !level_restart;
    assign w_eval       = (r_state == ST_SCAN);

    // Shared comparator: select the current table entry.
    always_comb begin
        w_sx     = '0;
        w_sy     = '0;
        w_cur_en = 1'b0;
        for (int i = 0; i < NUM_STARS; i++) begin
            if (r_idx == 3'(i)) begin
                w_sx     = star_xs[i*10 +: 10];
                w_sy     = star_ys[i*10 +: 10];
                w_cur_en = w_testable[i];
            end
        end
    end

    // Sums wrap at 10 bits by construction.
    assign w_cx_s = r_cx + c_size;
    assign w_cy_s = r_cy + c_size;
    assign w_sx_s = w_sx + c_size;
    assign w_sy_s = w_sy + c_size;

    assign w_xhit = ((r_cx >= w_sx) && (r_cx <= w_sx_s)) ||
                    ((w_cx_s >= w_sx) && (w_cx_s <= w_sx_s));
    assign w_yhit = ((r_cy >= w_sy) && (r_cy <= w_sy_s)) ||
                    ((w_cy_s >= w_sy) && (w_cy_s <= w_sy_s));
    assign w_hit  = w_eval && w_xhit && w_yhit && w_cur_en;

    always_comb begin
        w_hit_mask = '0;
        for (int i = 0; i < NUM_STARS; i++) begin
            w_hit_mask[i] = w_hit && (r_idx == 3'(i));
        end
    end

`ifdef STAR_RESPAWN_EN
    localparam int c_tw = $clog2(RESPAWN_FRAMES + 1);

    logic [c_tw-1:0]      r_timer [NUM_STARS];
    logic [NUM_STARS-1:0] r_fresh;

    always_comb begin
        w_respawn = '0;
        for (int i = 0; i < NUM_STARS; i++) begin
            w_respawn[i] = frame_tick && !r_star_en[i] && (r_timer[i] == c_tw'(1));
        end
    end

    // Stars revived during a scan sit out the remainder of that scan.
    assign w_testable = r_star_en & ~r_fresh;

    always_ff @(posedge sys_clk) begin
        if (RST || level_restart) begin
            r_fresh <= '0;
            for (int i = 0; i < NUM_STARS; i++) begin
                r_timer[i] <= '0;
            end
        end else begin
            r_fresh <= w_scan_start ? w_respawn : (r_fresh | w_respawn);
            for (int i = 0; i < NUM_STARS; i++) begin
                if (w_hit_mask[i]) begin
                    r_timer[i] <= c_tw'(RESPAWN_FRAMES);
                end else if (frame_tick && !r_star_en[i] && (r_timer[i] != '0)) begin
                    r_timer[i] <= r_timer[i] - c_tw'(1);
                end
            end
        end
    end
`else
    assign w_respawn  = '0;
    assign w_testable = r_star_en;
`endif

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            r_cx        <= '0;
            r_cy        <= '0;
            r_idx       <= '0;
            r_star_en   <= '1;
            r_touch     <= 1'b0;
            r_touch_idx <= '0;
            r_count     <= '0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= (r_state == ST_DONE) && !level_restart;
            r_touch     <= 1'b0;
            if (w_scan_start) begin
                r_cx  <= char_X;
                r_cy  <= char_Y;
                r_idx <= '0;
            end else if (w_eval && (r_idx != c_last)) begin
                r_idx <= r_idx + 3'd1;
            end
            if (level_restart) begin
                r_star_en <= '1;
                r_count   <= '0;
            end else begin
                r_star_en <= (r_star_en | w_respawn) & ~w_hit_mask;
                if (w_hit) begin
                    r_touch     <= 1'b1;
                    r_touch_idx <= r_idx;
                    if (r_count != 8'hFF) begin
                        r_count <= r_count + 8'd1;
                    end
                end
            end
        end
    end

    assign star_en    = r_star_en;
    assign touch      = r_touch;
    assign touch_idx  = r_touch_idx;
    assign star_count = r_count;
    assign scan_done  = r_scan_done;
    assign busy       = (r_state == ST_SCAN) || (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/star_scheduler.md
Name: star_scheduler

Overview:
- Central controller for all collectible stars in a level.
- Replaces per-star collision blocks with one shared overlap comparator, time-multiplexed round-robin over a star table once per frame.
- Owns every star's enable bit and emits per-star touch pulses and a saturating collected-star count to the score/HUD logic.
- Sits between the character-position logic (char_X/char_Y) and the star renderer/score counter.

Parameters:
- NUM_STARS, 4, number of stars in the table (2..8).
- STAR_SIZE, 12, bounding-box extent in pixels added to the base coordinate for both star and character.
- RESPAWN_FRAMES, 120, frame ticks before a collected star reappears (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; starts a scan.
- level_restart  in  1  one-cycle pulse; re-enables all stars and clears the count.
- char_X  in  10  character world X.
- char_Y  in  10  character world Y.
- star_xs  in  10*NUM_STARS  packed star world X; star i at bits [10i+9:10i].
- star_ys  in  10*NUM_STARS  packed star world Y, same packing.
- star_en  out  NUM_STARS  per-star visible/active bit.
- touch  out  1  one-cycle pulse when an enabled star is collected.
- touch_idx  out  3  index of the star collected; valid while touch=1.
- star_count  out  8  total stars collected since reset/restart; saturates at 255.
- scan_done  out  1  one-cycle pulse at the end of each scan.
- busy  out  1  high while in SCAN or DONE.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State=IDLE.
  - star_en = all ones, touch=0, touch_idx=0, star_count=0, scan_done=0, busy=0.
  - Scan index = 0; respawn timers = 0.
  - Reset mid-scan aborts the scan with no touch.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on frame_tick. On that edge, snapshot char_X/char_Y into registers and set idx=0.
  - SCAN: evaluate star idx on each edge using the snapshot.
    - idx < NUM_STARS-1: idx++.
    - idx = NUM_STARS-1: go to DONE.
  - DONE: scan_done=1 for exactly one cycle, then IDLE.
  - frame_tick during SCAN or DONE is ignored; it is not queued.
- Timing: if frame_tick is sampled at edge k:
  - star i is evaluated at edge k+1+i, so touch/touch_idx for star i are high in the cycle after edge k+1+i.
  - scan_done is high in the cycle after edge k+1+NUM_STARS.
  - busy is high from edge k through edge k+1+NUM_STARS.
- Hit rule: S=STAR_SIZE. All sums are 10-bit and wrap mod 1024.
  - xhit = (cX >= sx && cX <= sx+S) || (cX+S >= sx && cX+S <= sx+S)
  - yhit: same form using cY and sy.
  - hit = xhit && yhit && star_en[idx].
- On hit:
  - star_en[idx] <= 0.
  - touch <= 1, touch_idx <= idx.
  - star_count <= star_count+1, holding at 255 once reached.
  - Otherwise touch <= 0.
- A disabled star never produces touch.
- At most one touch per cycle; multiple overlapping stars are collected on consecutive cycles.
- level_restart:
  - Sets star_en to all ones, star_count=0, and clears all respawn timers. Evaluated in any state.
  - Aborts an in-progress scan: state goes to IDLE with no scan_done.
  - If coincident with a hit, restart wins: no touch, enables set.
  - If coincident with frame_tick in IDLE, restart wins and no scan starts.
- touch_idx holds its last value while touch=0.

Optional Feature:
- Macro: STAR_RESPAWN_EN.
- When defined:
  - Each star has a timer that loads RESPAWN_FRAMES on collection and decrements on every frame_tick while star_en[i]=0.
  - On the frame_tick where it would go from 1 to 0, star_en[i] <= 1 at that edge. A re-enabled star is not hit-tested until the next scan.
  - level_restart clears the timers.
- When undefined:
  - No timers are built; collected stars stay disabled until RST or level_restart.

Test Plan:
- Reset, then char=(200,100) with all stars at x=1..61,y=306, pulse frame_tick -> no touch, scan_done high exactly NUM_STARS+1 cycles after the tick edge, star_en=4'b1111.
- Star2 at (1,306), char=(5,300), tick -> touch with touch_idx=2 in the cycle after edge k+3; star_en=4'b1011; star_count=1; a second tick gives no touch.
- Stars 0 and 3 both at (100,100), char=(95,95) -> touch on two separated cycles (idx 0, then idx 3); star_count=2.
- Boundary case: star at (50,50), char=(38,50) (cX+S=50) -> hit. Char=(37,50) -> no hit. Char=(63,50) (sx+S+1) -> no hit.
- Assert RST mid-scan after idx=1 -> no further touch, no scan_done, star_en=4'b1111, busy=0. Separately, level_restart coincident with a hit -> touch=0, star_count=0.
- With STAR_RESPAWN_EN and RESPAWN_FRAMES=3: collect star 1 -> star_en[1]=0 for ticks 1-2 and =1 after the 3rd tick edge. Without the macro, the star stays 0 after 10 ticks.
